half_duplex_bus_ctrl: RTL and testbench

Direction and timing controller for a half-duplex shared data bus. It sits directly upstream of `bidirectional_buffer` and generates that buffer's enable and outbound data. It serialises local write and read requests onto the single bus. A turnaround gap is enforced after every transaction so the local driver and the remote driver never overlap.

---
 rtl/half_duplex_bus_ctrl_pkg.sv | 22 ++
 rtl/half_duplex_bus_ctrl_timer.sv | 27 ++
 rtl/half_duplex_bus_ctrl.sv | 128 ++++++++++++
 tb/tb_half_duplex_bus_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/half_duplex_bus_ctrl_pkg.sv
// Shared constants for the half-duplex bus controller:
// FSM state encodings, default geometry and a sizing helper.
package half_duplex_bus_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_TURN   = 3'd4;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_WR_HOLD = 2;
    localparam int DEF_RD_WAIT = 2;
    localparam int DEF_TA      = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/half_duplex_bus_ctrl_timer.sv
// Loadable down-counter shared by the DRIVE, SAMPLE and TURN phases;
// done is high whenever the count has reached zero.
module bus_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/half_duplex_bus_ctrl.sv
// Half-duplex bus direction controller: serialises local writes and
// reads onto one bus and enforces a released turnaround after each.
module half_duplex_bus_ctrl
    import half_duplex_bus_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int WR_HOLD = DEF_WR_HOLD,
    parameter int RD_WAIT = DEF_RD_WAIT,
    parameter int TA      = DEF_TA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic             bus_en,
    output logic [WIDTH-1:0] bus_out,
    input  logic [WIDTH-1:0] bus_in,
    output logic             busy
);

    localparam int CW = $clog2(max3(WR_HOLD, RD_WAIT, TA)) + 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(WR_HOLD - 1);
    localparam logic [CW-1:0] WAIT_LD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] TURN_LD = CW'(TA - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_done;
    logic [WIDTH-1:0] wr_word;

    bus_phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write has priority; a held read is picked up on the next IDLE cycle.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state)
            ST_IDLE: begin
                if (wr_valid) begin
                    state_nxt = ST_DRIVE;
                    tmr_load  = 1'b1;
                    tmr_val   = HOLD_LD;
                end else if (rd_req) begin
                    state_nxt = ST_SAMPLE;
                    tmr_load  = 1'b1;
                    tmr_val   = WAIT_LD;
                end
            end
            ST_DRIVE: begin
                if (tmr_done) begin
                    state_nxt = ST_TURN;
                    tmr_load  = 1'b1;
                    tmr_val   = TURN_LD;
                end
            end
            ST_SAMPLE: begin
                if (tmr_done) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rd_ready) begin
                    state_nxt = ST_TURN;
                    tmr_load  = 1'b1;
                    tmr_val   = TURN_LD;
                end
            end
            ST_TURN: begin
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_word <= '0;
            rd_data <= '0;
        end else begin
            if (state == ST_IDLE && wr_valid) begin
                wr_word <= wr_data;
            end
            if (state == ST_SAMPLE && tmr_done) begin
                rd_data <= bus_in;
            end
        end
    end

    // Everything below decodes the state register only, so reset
    // releases the bus without waiting for a clock edge.
    always_comb begin
        wr_ready = (state == ST_IDLE);
        bus_en   = (state == ST_DRIVE);
        bus_out  = (state == ST_DRIVE) ? wr_word : '0;
        rd_valid = (state == ST_RESP);
        busy     = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_half_duplex_bus_ctrl.sv
// Bench for half_duplex_bus_ctrl: directed and random stimulus checked
// against a timeline model, on default and swept parameter sets.
module tb_half_duplex_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_req = 1'b0;
    logic       rd_ready = 1'b0;
    logic [7:0] bus_in = '0;

    logic       a_wr_ready, a_rd_valid, a_bus_en, a_busy;
    logic [7:0] a_rd_data, a_bus_out;
    logic       b_wr_ready, b_rd_valid, b_bus_en, b_busy;
    logic [7:0] b_rd_data, b_bus_out;

    always #5 clk = ~clk;

    half_duplex_bus_ctrl u_dut_a (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(a_wr_ready),
        .rd_req(rd_req), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .rd_ready(rd_ready), .bus_en(a_bus_en), .bus_out(a_bus_out),
        .bus_in(bus_in), .busy(a_busy)
    );

    half_duplex_bus_ctrl #(
        .WIDTH(8), .WR_HOLD(1), .RD_WAIT(1), .TA(3)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(b_wr_ready),
        .rd_req(rd_req), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .rd_ready(rd_ready), .bus_en(b_bus_en), .bus_out(b_bus_out),
        .bus_in(bus_in), .busy(b_busy)
    );

    bit sel = 1'b0;
    logic       o_wr_ready, o_rd_valid, o_bus_en, o_busy;
    logic [7:0] o_rd_data, o_bus_out;

    always_comb begin
        o_wr_ready = sel ? b_wr_ready : a_wr_ready;
        o_rd_valid = sel ? b_rd_valid : a_rd_valid;
        o_bus_en   = sel ? b_bus_en   : a_bus_en;
        o_busy     = sel ? b_busy     : a_busy;
        o_rd_data  = sel ? b_rd_data  : a_rd_data;
        o_bus_out  = sel ? b_bus_out  : a_bus_out;
    end

    int errs = 0;
    int checks = 0;

    // Timeline model: cycle n is the interval following clock edge n.
    int wh = 2, rw = 2, ta = 1;
    int cyc = 0;
    int idle_from, drv_lo, drv_hi, smp_hi, resp_from, last_act;
    bit in_read, prev_en;
    logic [7:0] drv_word, rd_exp;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        idle_from = 0;
        drv_lo    = 1;
        drv_hi    = 0;
        in_read   = 1'b0;
        rd_exp    = '0;
        drv_word  = '0;
        last_act  = -1;
        prev_en   = 1'b0;
    endtask

    function automatic bit model_idle();
        return !in_read && cyc >= idle_from;
    endfunction

    task automatic check_outputs();
        bit idle, en;
        idle = model_idle();
        en   = (cyc >= drv_lo) && (cyc <= drv_hi);
        chk("wr_ready", o_wr_ready, idle);
        chk("busy", o_busy, !idle);
        chk("bus_en", o_bus_en, en);
        chk("bus_out", o_bus_out, en ? drv_word : 8'h00);
        chk("rd_valid", o_rd_valid, in_read && cyc >= resp_from);
        chk("rd_data", o_rd_data, rd_exp);
        if (o_bus_en === 1'b1 && !prev_en && last_act >= 0)
            chk("turn_gap", (cyc - last_act - 1) >= ta, 1'b1);
        if (o_bus_en === 1'b1 || o_rd_valid === 1'b1)
            last_act = cyc;
        prev_en = (o_bus_en === 1'b1);
    endtask

    task automatic edge_update();
        int c, e;
        bit idle;
        c = cyc;
        e = cyc + 1;
        idle = model_idle();
        if (rst) begin
            model_reset();
        end else if (idle && wr_valid) begin
            drv_lo    = e;
            drv_hi    = e + wh - 1;
            drv_word  = wr_data;
            idle_from = e + wh + ta;
        end else if (idle && rd_req) begin
            in_read   = 1'b1;
            smp_hi    = e + rw - 1;
            resp_from = e + rw;
        end else if (in_read && c == smp_hi) begin
            rd_exp = bus_in;
        end else if (in_read && c >= resp_from && rd_ready) begin
            in_read   = 1'b0;
            idle_from = e + ta;
        end
        cyc = e;
    endtask

    task automatic step(input bit wv, input logic [7:0] wd, input bit rr,
                        input bit rdy, input logic [7:0] bi);
        @(negedge clk);
        check_outputs();
        wr_valid = wv;
        wr_data  = wd;
        rd_req   = rr;
        rd_ready = rdy;
        bus_in   = bi;
        @(posedge clk);
        edge_update();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 1, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        idle_steps(3);
        #1 rst = 1'b0;
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++)
            step(($urandom % 4) == 0, 8'($urandom), ($urandom % 3) == 0,
                 ($urandom % 2) == 0, 8'($urandom));
    endtask

    initial begin
        logic [7:0] words [3];
        int n;
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;

        model_reset();
        do_reset();
        idle_steps(3);

        step(1, 8'hA5, 0, 1, 8'h00);
        idle_steps(5);

        step(0, 8'h00, 1, 0, 8'h3C);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 8'h3C);
        step(0, 8'h00, 0, 1, 8'h3C);
        idle_steps(3);

        step(1, 8'h5A, 1, 1, 8'h77);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 1, 8'h77);
        idle_steps(5);

        n = 0;
        while (n < 3) begin
            bit acc;
            acc = model_idle();
            step(1, words[n], 0, 1, 8'h00);
            if (acc) n++;
        end
        idle_steps(5);

        step(1, 8'hC3, 0, 1, 8'h00);
        step(0, 8'h00, 0, 1, 8'h00);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs();
        @(posedge clk);
        edge_update();
        #1 rst = 1'b0;
        idle_steps(3);

        random_steps(400);

        sel = 1'b1;
        wh = 1;
        rw = 1;
        ta = 3;
        do_reset();
        step(1, 8'h81, 0, 1, 8'h00);
        step(1, 8'h82, 1, 1, 8'h9E);
        for (int i = 0; i < 10; i++) step(1, 8'h83, 1, 1, 8'h9E);
        random_steps(400);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
